priority_interrupt_controller: RTL and testbench
================================================

PRIORITY_INTERRUPT_CONTROLLER -- requirements
Module: priority_interrupt_controller

Interface
REQ-001 SHALL have parameter N, default 8, number of request channels (2..32).
REQ-002 SHALL have parameter ROUND_ROBIN, default 0, arbitration mode: 0 fixed priority, 1 rotating priority.
REQ-003 SHALL have derived local parameter IDW = ceil(log2(N)), the width of the channel index.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port E  input  1  grant enable; 0 blocks new grants, capture continues.
REQ-007 SHALL have port D  input  N  request lines, level inputs, rising edge = new request.
REQ-008 SHALL have port mask  input  N  per-channel enable; 1 = channel eligible for grant.
REQ-009 SHALL have port ack  input  1  acknowledge of the currently granted channel.
REQ-010 SHALL have port irq  output  1  registered; 1 while a grant is outstanding.
REQ-011 SHALL have port B  output  IDW  registered index of the granted channel, valid while irq=1.
REQ-012 SHALL have port pending  output  N  registered pending-request vector.

Function
REQ-013 SHALL register D each cycle into d_prev; pending[i] SHALL set on the edge where D[i]=1 and d_prev[i]=0.
REQ-014 SHALL keep pending[i] set until cleared by ack of channel i or by reset; masking SHALL NOT clear it.
REQ-015 SHALL implement FSM states IDLE and SERVE; irq = (state == SERVE).
REQ-016 IDLE -> SERVE SHALL occur when E=1 and (pending & mask) != 0; B SHALL load the winner on the same edge.
REQ-017 Fixed mode: winner SHALL be the highest-index eligible channel (bit N-1 highest priority).
REQ-018 Rotating mode: search SHALL start at last+1 and wrap modulo N toward increasing index; first eligible channel wins; last SHALL update to B on each ack.
REQ-019 SERVE: B SHALL stay constant; changes in D, mask or E SHALL NOT alter B or irq.
REQ-020 SERVE with ack=1: pending[B] SHALL clear and state SHALL return to IDLE on that edge; irq=0 for at least one cycle before the next grant.
REQ-021 ack in IDLE SHALL be ignored.
REQ-022 Same-edge new rising edge on D[B] and ack SHALL leave pending[B]=1 (set wins).
REQ-023 Latency: D[i] rises before edge t -> pending[i]=1 after t; with channel eligible and state IDLE, irq=1 and B=i after edge t+1.
REQ-024 E=0 during SERVE SHALL NOT abort the grant; it only prevents the next IDLE -> SERVE.
REQ-025 Mask of the granted channel deasserting during SERVE SHALL NOT abort the grant.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, irq=0, B=0, pending=0, d_prev=0, last=N-1.
REQ-027 Reset mid-SERVE SHALL discard the grant and all pending requests.
REQ-028 After reset release, a D line already held at 1 SHALL count as a rising edge on the first clock (d_prev=0).

Verification
REQ-029 Fixed, N=8, mask=FF, E=1: D=0000_0001 pulse -> pending=01 after t, irq=1 and B=0 after t+1; ack -> irq=0, pending=00.
REQ-030 Fixed: D=0100_1010 on same edge -> grants in order B=6, 3, 1 with one ack each and irq low one cycle between them.
REQ-031 Rotating: D=1000_0001 simultaneous, last=7 after reset -> B=0 first, then B=7; repeat pattern -> B=0 again.
REQ-032 mask=FE, D[0] rises -> pending=01, irq stays 0; mask=FF -> irq=1, B=0 next cycle.
REQ-033 E=0 with pending=04 -> irq stays 0; E=1 -> irq=1, B=2; D[2] re-rises on the ack edge -> pending stays 04, re-granted.
REQ-034 rst pulse during SERVE with pending=F0 -> irq=0, B=0, pending=00 immediately, before the next clock edge.

Source files
------------

// File: rtl/priority_interrupt_controller.sv
// rtl/priority_interrupt_controller.sv - edge-captured interrupt requests with fixed or rotating priority grant
module priority_interrupt_controller #(
  parameter int N           = 8,
  parameter int ROUND_ROBIN = 0,
  localparam int IDW        = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           E,
  input  logic [N-1:0]   D,
  input  logic [N-1:0]   mask,
  input  logic           ack,
  output logic           irq,
  output logic [IDW-1:0] B,
  output logic [N-1:0]   pending
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t         state;
  logic [N-1:0]   d_prev;
  logic [IDW-1:0] last;
  logic [N-1:0]   eligible;
  logic [N-1:0]   set_vec;
  logic [N-1:0]   clr_vec;
  logic [IDW-1:0] win;
  logic [IDW-1:0] sel;
  int             tmp;

  assign eligible = pending & mask;
  assign set_vec  = D & ~d_prev;

  always_comb begin
    clr_vec = '0;
    if (state == SERVE && ack) clr_vec[B] = 1'b1;
  end

  // Rotating search scans from the far end back toward last+1 so the first
  // eligible channel after last is the final assignment and therefore wins.
  always_comb begin
    win = '0;
    sel = '0;
    tmp = 0;
    if (ROUND_ROBIN != 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        tmp = int'(last) + 1 + k;
        if (tmp >= N) tmp = tmp - N;
        sel = IDW'(tmp);
        if (eligible[sel]) win = sel;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (eligible[i]) win = IDW'(i);
      end
    end
  end

  // A rising edge arriving with the ack wins, so set is applied after clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      irq     <= 1'b0;
      B       <= '0;
      pending <= '0;
      d_prev  <= '0;
      last    <= IDW'(N - 1);
    end else begin
      d_prev  <= D;
      pending <= (pending & ~clr_vec) | set_vec;
      case (state)
        IDLE: begin
          if (E && (|eligible)) begin
            state <= SERVE;
            irq   <= 1'b1;
            B     <= win;
          end
        end
        SERVE: begin
          if (ack) begin
            state <= IDLE;
            irq   <= 1'b0;
            last  <= B;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_interrupt_controller.sv
// tb/tb_priority_interrupt_controller.sv - bench for fixed and rotating priority interrupt controller
module tb_priority_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       e_f, ack_f, e_r, ack_r;
  logic [7:0] d_f, mask_f, d_r, mask_r;
  logic       irq_f, irq_r;
  logic [2:0] b_f, b_r;
  logic [7:0] pend_f, pend_r;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    logic       e;
    logic [7:0] d;
    logic [7:0] mask;
    logic       ack;
    logic       irq;
    logic [2:0] b;
    logic [7:0] pend;
  } vec_t;

  typedef struct {
    string      name;
    bit         rr;
    logic       irq;
    logic [2:0] b;
    logic [7:0] pend;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  priority_interrupt_controller #(.N(8), .ROUND_ROBIN(0)) dut_f (
    .clk(clk), .rst(rst), .E(e_f), .D(d_f), .mask(mask_f), .ack(ack_f),
    .irq(irq_f), .B(b_f), .pending(pend_f)
  );

  priority_interrupt_controller #(.N(8), .ROUND_ROBIN(1)) dut_r (
    .clk(clk), .rst(rst), .E(e_r), .D(d_r), .mask(mask_r), .ack(ack_r),
    .irq(irq_r), .B(b_r), .pending(pend_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_outputs(input exp_t x);
    if (x.rr) begin
      check({x.name, ".irq"}, 32'(irq_r), 32'(x.irq));
      check({x.name, ".B"}, 32'(b_r), 32'(x.b));
      check({x.name, ".pending"}, 32'(pend_r), 32'(x.pend));
    end else begin
      check({x.name, ".irq"}, 32'(irq_f), 32'(x.irq));
      check({x.name, ".B"}, 32'(b_f), 32'(x.b));
      check({x.name, ".pending"}, 32'(pend_f), 32'(x.pend));
    end
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, then score it.
  task automatic cycle(input bit rr, input vec_t v);
    exp_t x;
    if (rr) begin
      e_r = v.e; d_r = v.d; mask_r = v.mask; ack_r = v.ack;
    end else begin
      e_f = v.e; d_f = v.d; mask_f = v.mask; ack_f = v.ack;
    end
    sb.push_back('{name: v.name, rr: rr, irq: v.irq, b: v.b, pend: v.pend});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      x = sb.pop_front();
      compare_outputs(x);
    end
  endtask

  task automatic add(input string n, input logic e, input logic [7:0] d, input logic [7:0] m,
                     input logic a, input logic i, input logic [2:0] b, input logic [7:0] p);
    tbl.push_back('{name: n, e: e, d: d, mask: m, ack: a, irq: i, b: b, pend: p});
  endtask

  initial begin
    vec_t v;
    exp_t x;

    rst = 1'b1;
    e_f = 0; d_f = 0; mask_f = 8'hFF; ack_f = 0;
    e_r = 1; d_r = 0; mask_r = 8'hFF; ack_r = 0;

    //    name          E  D      mask   ack irq B  pending
    add("single_cap",   1, 8'h01, 8'hFF, 0, 0, 0, 8'h01);
    add("single_grant", 1, 8'h00, 8'hFF, 0, 1, 0, 8'h01);
    add("single_ack",   1, 8'h00, 8'hFF, 1, 0, 0, 8'h00);
    add("multi_cap",    1, 8'h4A, 8'hFF, 0, 0, 0, 8'h4A);
    add("multi_g6",     1, 8'h00, 8'hFF, 0, 1, 6, 8'h4A);
    add("multi_a6",     1, 8'h00, 8'hFF, 1, 0, 6, 8'h0A);
    add("multi_g3",     1, 8'h00, 8'hFF, 0, 1, 3, 8'h0A);
    add("multi_a3",     1, 8'h00, 8'hFF, 1, 0, 3, 8'h02);
    add("multi_g1",     1, 8'h00, 8'hFF, 0, 1, 1, 8'h02);
    add("multi_a1",     1, 8'h00, 8'hFF, 1, 0, 1, 8'h00);
    add("idle_ack",     1, 8'h00, 8'hFF, 1, 0, 1, 8'h00);
    add("mask_cap",     1, 8'h01, 8'hFE, 0, 0, 1, 8'h01);
    add("mask_hold",    1, 8'h00, 8'hFE, 0, 0, 1, 8'h01);
    add("mask_open",    1, 8'h00, 8'hFF, 0, 1, 0, 8'h01);
    add("serve_stable", 0, 8'h80, 8'h00, 0, 1, 0, 8'h81);
    add("serve_ack",    1, 8'h00, 8'hFF, 1, 0, 0, 8'h80);
    add("grant7",       1, 8'h00, 8'hFF, 0, 1, 7, 8'h80);
    add("ack7",         1, 8'h00, 8'hFF, 1, 0, 7, 8'h00);
    add("e0_cap",       0, 8'h04, 8'hFF, 0, 0, 7, 8'h04);
    add("e0_hold",      0, 8'h00, 8'hFF, 0, 0, 7, 8'h04);
    add("e1_grant2",    1, 8'h00, 8'hFF, 0, 1, 2, 8'h04);
    add("set_wins",     1, 8'h04, 8'hFF, 1, 0, 2, 8'h04);
    add("regrant2",     1, 8'h04, 8'hFF, 0, 1, 2, 8'h04);
    add("final_ack",    1, 8'h00, 8'hFF, 1, 0, 2, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    x = '{name: "reset_f", rr: 0, irq: 0, b: 0, pend: 0};
    compare_outputs(x);
    x = '{name: "reset_r", rr: 1, irq: 0, b: 0, pend: 0};
    compare_outputs(x);
    rst = 1'b0;
    e_f = 1'b1;

    foreach (tbl[i]) cycle(0, tbl[i]);

    // Rotating: last starts at N-1, so channel 0 precedes channel 7.
    v = '{name: "rr_cap",  e: 1, d: 8'h81, mask: 8'hFF, ack: 0, irq: 0, b: 0, pend: 8'h81}; cycle(1, v);
    v = '{name: "rr_g0",   e: 1, d: 8'h00, mask: 8'hFF, ack: 0, irq: 1, b: 0, pend: 8'h81}; cycle(1, v);
    v = '{name: "rr_a0",   e: 1, d: 8'h00, mask: 8'hFF, ack: 1, irq: 0, b: 0, pend: 8'h80}; cycle(1, v);
    v = '{name: "rr_g7",   e: 1, d: 8'h00, mask: 8'hFF, ack: 0, irq: 1, b: 7, pend: 8'h80}; cycle(1, v);
    v = '{name: "rr_a7",   e: 1, d: 8'h00, mask: 8'hFF, ack: 1, irq: 0, b: 7, pend: 8'h00}; cycle(1, v);
    v = '{name: "rr_cap2", e: 1, d: 8'h81, mask: 8'hFF, ack: 0, irq: 0, b: 7, pend: 8'h81}; cycle(1, v);
    v = '{name: "rr_g0b",  e: 1, d: 8'h00, mask: 8'hFF, ack: 0, irq: 1, b: 0, pend: 8'h81}; cycle(1, v);

    // Asynchronous reset in the middle of a grant with several pending.
    v = '{name: "rst_cap",   e: 1, d: 8'hF0, mask: 8'hFF, ack: 0, irq: 0, b: 2, pend: 8'hF0}; cycle(0, v);
    v = '{name: "rst_grant", e: 1, d: 8'h00, mask: 8'hFF, ack: 0, irq: 1, b: 7, pend: 8'hF0}; cycle(0, v);
    #2 rst = 1'b1;
    d_f = 8'h01;
    #1;
    x = '{name: "async_rst", rr: 0, irq: 0, b: 0, pend: 8'h00};
    compare_outputs(x);
    @(posedge clk);
    #1 rst = 1'b0;
    v = '{name: "held_high", e: 1, d: 8'h01, mask: 8'hFF, ack: 0, irq: 0, b: 0, pend: 8'h01}; cycle(0, v);
    v = '{name: "held_grant", e: 1, d: 8'h01, mask: 8'hFF, ack: 0, irq: 1, b: 0, pend: 8'h01}; cycle(0, v);

    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
